seq_comparator: RTL and testbench
=================================

SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 Parameter N, default 32: operand width in bits.
REQ-002 Parameter W, default 8: chunk width compared per cycle; N SHALL be an integer multiple of W; K = N/W.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port s, input, 1: 1 = signed (two's complement) compare, 0 = unsigned compare.
REQ-006 Port a, b, input, N each: operands.
REQ-007 Port in_valid / in_ready, input / output, 1 each: operand handshake.
REQ-008 Port o, output, 6: flags {eq, ne, lt, le, gt, ge}.
REQ-009 Port out_valid / out_ready, output / input, 1 each: result handshake.
REQ-010 Port busy, output, 1: high while not in IDLE.

Function
REQ-011 s, a and b SHALL be captured on the edge where in_valid && in_ready; in_ready SHALL be high only in IDLE.
REQ-012 The FSM SHALL have states IDLE -> CMP on capture, CMP -> DONE on decision, and DONE -> IDLE on out_valid && out_ready.
REQ-013 CMP SHALL examine one W-bit chunk per cycle, MSB chunk first, index i = 0..K-1.
REQ-014 Chunk 0 SHALL be compared signed when s=1; all other chunks SHALL be compared unsigned.
REQ-015 The first unequal chunk SHALL decide the result, lt or gt per that chunk; if all K chunks are equal, the result SHALL be EQ.
REQ-016 o SHALL equal 6'b011100 (LT), 6'b100101 (EQ) or 6'b010011 (GT), and SHALL be registered.
REQ-017 With early exit, out_valid SHALL rise i+1 cycles after the capture edge for deciding chunk i, and K cycles after it when all chunks are equal.
REQ-018 o and out_valid SHALL hold stable in DONE until out_ready; there is no back-to-back bypass, so IDLE lasts at least one cycle.
REQ-019 in_valid while busy SHALL be ignored; captured operands SHALL NOT change for the rest of the transaction.
REQ-020 When K=1, a result SHALL appear 1 cycle after capture.

Reset
REQ-021 While rst_n=0, outputs SHALL be: state IDLE, out_valid=0, in_ready=1, busy=0, o=6'b000000, chunk index 0.
REQ-022 Reset asserted mid-CMP or in DONE SHALL abort the transaction immediately; no result SHALL be delivered.

Configuration
REQ-023 Macro SEQ_COMPARATOR_EARLY_EXIT_EN defined: behaviour is as in REQ-017.
REQ-024 Macro SEQ_COMPARATOR_EARLY_EXIT_EN undefined: CMP SHALL always run K cycles, the first differing chunk is latched as the decision, and latency SHALL be a constant K.

Structure
REQ-025 Package cmp_pkg SHALL hold the LT/EQ/GT flag constants, the state enum typedef {IDLE, CMP, DONE} and the flag-vector typedef.
REQ-026 The per-chunk compare SHALL be one instance of sub-module comparator #(W), with its s input driven by (s && i==0).
REQ-027 The chunk index counter SHALL be $clog2(K) bits wide, with a minimum of 1 bit.

Verification (N=32, W=8, early exit on unless stated)
REQ-028 Unsigned ordering: s=0, a=0, b=1 -> LT, out_valid at capture+4.
REQ-029 Signed MSB decision: s=1, a=0x80000000, b=0x00000001 -> LT at capture+1; with s=0 -> GT at capture+1.
REQ-030 All-ones equality: a=b=0xFFFFFFFF with s=0 and s=1 -> EQ at capture+4.
REQ-031 Backpressure: out_ready held low 3 cycles -> o and out_valid stable, in_ready=0, and a new in_valid pulse is ignored.
REQ-032 Reset in CMP: rst_n pulsed low during chunk 1 -> out_valid=0, in_ready=1 immediately; the next transaction (a=5, b=3, s=0) -> GT correct.
REQ-033 Early exit off: macro undefined, the REQ-029 stimulus -> LT at capture+4.

Source files
------------

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and flag constants for the sequential comparator
// Contents: state enum {IDLE, CMP, DONE}, flag vector type {eq, ne, lt, le, gt, ge},
// and the LT / EQ / GT / NONE flag encodings.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  // {eq, ne, lt, le, gt, ge}
  typedef logic [5:0] cmp_flags_t;

  localparam cmp_flags_t FLAGS_LT   = 6'b011100;
  localparam cmp_flags_t FLAGS_EQ   = 6'b100101;
  localparam cmp_flags_t FLAGS_GT   = 6'b010011;
  localparam cmp_flags_t FLAGS_NONE = 6'b000000;

endpackage

// File: rtl/comparator.sv
// rtl/comparator.sv - combinational W-bit magnitude compare, signed or unsigned
// Ports:
//   s     in  1 : 1 = two's complement compare, 0 = unsigned
//   a, b  in  W : chunk operands
//   lt    out 1 : a < b
//   gt    out 1 : a > b
module comparator #(
  parameter int W = 8
) (
  input  logic         s,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         gt
);

  always_comb begin
    lt = 1'b0;
    gt = 1'b0;
    if (s) begin
      lt = ($signed(a) < $signed(b));
      gt = ($signed(a) > $signed(b));
    end else begin
      lt = (a < b);
      gt = (a > b);
    end
  end

endmodule

// File: rtl/seq_comparator.sv
// rtl/seq_comparator.sv - multi-cycle N-bit compare, one W-bit chunk per cycle, MSB chunk first
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   s, a, b                : sign mode and operands, captured on in_valid && in_ready
//   in_valid / in_ready    : operand handshake (ready only in IDLE)
//   o                      : registered flags {eq, ne, lt, le, gt, ge}
//   out_valid / out_ready  : result handshake, result held in DONE until accepted
//   busy                   : high whenever not IDLE
// Build option: SEQ_COMPARATOR_EARLY_EXIT_EN - leave CMP on the first unequal chunk;
// without it CMP always runs K cycles and latches the first differing chunk.
module seq_comparator
  import cmp_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [5:0]   o,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int K  = N / W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  cmp_state_e  state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          s_q, s_d;
  cmp_flags_t    o_q, o_d;
`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
  logic          decided_q, decided_d;
  cmp_flags_t    res_q, res_d;
`endif

  logic [SW-1:0] chunk_lsb;
  logic [W-1:0]  a_chunk;
  logic [W-1:0]  b_chunk;
  logic          chunk_lt;
  logic          chunk_gt;
  cmp_flags_t    chunk_res;

  // Chunk index 0 is the most significant chunk.
  always_comb begin
    chunk_lsb = SW'((K - 1 - int'(idx_q)) * W);
    a_chunk   = a_q[chunk_lsb +: W];
    b_chunk   = b_q[chunk_lsb +: W];
  end

  // Only the top chunk carries the sign bit; lower chunks are plain magnitude.
  comparator #(.W(W)) u_chunk_cmp (
    .s  (s_q && (idx_q == '0)),
    .a  (a_chunk),
    .b  (b_chunk),
    .lt (chunk_lt),
    .gt (chunk_gt)
  );

  always_comb begin
    chunk_res = FLAGS_EQ;
    if (chunk_lt)      chunk_res = FLAGS_LT;
    else if (chunk_gt) chunk_res = FLAGS_GT;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    o_d     = o_q;
`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
    decided_d = decided_q;
    res_d     = res_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          idx_d   = '0;
          state_d = CMP;
`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
          decided_d = 1'b0;
`endif
        end
      end
      CMP: begin
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
        if (chunk_lt || chunk_gt || (idx_q == LAST_IDX)) begin
          o_d     = chunk_res;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
`else
        // Keep scanning for a fixed latency; the first unequal chunk wins.
        if (!decided_q && (chunk_lt || chunk_gt)) begin
          decided_d = 1'b1;
          res_d     = chunk_res;
        end
        if (idx_q == LAST_IDX) begin
          o_d     = decided_q ? res_q : chunk_res;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          o_d     = FLAGS_NONE;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= 1'b0;
      o_q     <= FLAGS_NONE;
`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
      decided_q <= 1'b0;
      res_q     <= FLAGS_NONE;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      o_q     <= o_d;
`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
      decided_q <= decided_d;
      res_q     <= res_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign o         = o_q;

endmodule

// File: tb/tb_seq_comparator.sv
// tb/tb_seq_comparator.sv - randomized self-checking bench for seq_comparator (N=32/W=8 and N=8/W=8)
module tb_seq_comparator;

  localparam int N = 32;
  localparam int W = 8;
  localparam int K = N / W;
  localparam logic [5:0] LT = 6'b011100;
  localparam logic [5:0] EQ = 6'b100101;
  localparam logic [5:0] GT = 6'b010011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s = 1'b0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    o;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  logic          s1 = 1'b0;
  logic [7:0]    a1 = '0;
  logic [7:0]    b1 = '0;
  logic          in_valid1 = 1'b0;
  logic          in_ready1;
  logic [5:0]    o1;
  logic          out_valid1;
  logic          out_ready1 = 1'b0;
  logic          busy1;

  int checks = 0;
  int errors = 0;

  seq_comparator #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .o(o),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  seq_comparator #(.N(8), .W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .s(s1), .a(a1), .b(b1),
    .in_valid(in_valid1), .in_ready(in_ready1), .o(o1),
    .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1)
  );

  // Reference: whole-word arithmetic compare.
  function automatic logic [5:0] exp_flags(input logic sv, input logic [N-1:0] av, input logic [N-1:0] bv);
    if (av == bv) return EQ;
    if (sv) return ($signed(av) < $signed(bv)) ? LT : GT;
    return (av < bv) ? LT : GT;
  endfunction

  // Reference latency: position of the most significant differing bit picks the chunk.
  function automatic int exp_lat(input logic [N-1:0] av, input logic [N-1:0] bv);
    logic [N-1:0] x;
    int pos;
    x = av ^ bv;
    if (x == '0) return K;
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
    pos = 0;
    for (int p = N - 1; p >= 0; p--) begin
      if (x[p]) begin
        pos = p;
        break;
      end
    end
    return (N - 1 - pos) / W + 1;
`else
    return K;
`endif
  endfunction

  // Issues one transaction, reports flags and cycles from capture edge to out_valid (-1 on timeout).
  task automatic drive_txn(input logic sv, input logic [N-1:0] av, input logic [N-1:0] bv,
                           output logic [5:0] obs, output int lat);
    @(negedge clk);
    s = sv; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    s = ~sv; a = $urandom; b = $urandom;
    lat = -1;
    obs = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        obs = o;
        break;
      end
    end
    if (lat > 0) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || o !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b o=%b, want 1 0 0 000000",
               in_ready, out_valid, busy, o);
    end
    checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0 || o1 !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs_k1: in_ready=%b out_valid=%b busy=%b o=%b, want 1 0 0 000000",
               in_ready1, out_valid1, busy1, o1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_order();
    logic [5:0] obs;
    int lat;
    drive_txn(1'b0, 32'h0, 32'h1, obs, lat);
    checks++;
    if (obs !== LT || lat != 4) begin
      errors++;
      $display("FAIL unsigned_0_lt_1: o=%b lat=%0d, want %b lat=4", obs, lat, LT);
    end
  endtask

  task automatic test_signed_msb();
    logic [5:0] obs;
    int lat;
    drive_txn(1'b1, 32'h8000_0000, 32'h0000_0001, obs, lat);
    checks++;
    if (obs !== LT || lat != exp_lat(32'h8000_0000, 32'h1)) begin
      errors++;
      $display("FAIL signed_msb_lt: o=%b lat=%0d, want %b lat=%0d", obs, lat, LT,
               exp_lat(32'h8000_0000, 32'h1));
    end
    drive_txn(1'b0, 32'h8000_0000, 32'h0000_0001, obs, lat);
    checks++;
    if (obs !== GT || lat != exp_lat(32'h8000_0000, 32'h1)) begin
      errors++;
      $display("FAIL unsigned_msb_gt: o=%b lat=%0d, want %b lat=%0d", obs, lat, GT,
               exp_lat(32'h8000_0000, 32'h1));
    end
  endtask

  task automatic test_all_ones();
    logic [5:0] obs;
    int lat;
    for (int sv = 0; sv < 2; sv++) begin
      drive_txn(sv[0], 32'hFFFF_FFFF, 32'hFFFF_FFFF, obs, lat);
      checks++;
      if (obs !== EQ || lat != 4) begin
        errors++;
        $display("FAIL all_ones_eq s=%0d: o=%b lat=%0d, want %b lat=4", sv, obs, lat, EQ);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] obs;
    int lat;
    logic sv;
    logic [N-1:0] av, bv;
    for (int t = 0; t < 60; t++) begin
      sv = 1'($urandom);
      av = $urandom;
      case ($urandom_range(0, 3))
        0: bv = av;
        1: bv = av ^ (N'($urandom_range(1, 255)) << (W * $urandom_range(0, K - 1)));
        2: bv = av ^ N'(32'h8000_0000);
        default: bv = $urandom;
      endcase
      drive_txn(sv, av, bv, obs, lat);
      checks++;
      if (obs !== exp_flags(sv, av, bv) || lat != exp_lat(av, bv)) begin
        errors++;
        $display("FAIL random_txn s=%b a=%h b=%h: o=%b lat=%0d, want %b lat=%0d",
                 sv, av, bv, obs, lat, exp_flags(sv, av, bv), exp_lat(av, bv));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] held;
    int seen;
    int bad;
    @(negedge clk);
    s = 1'b0; a = 32'h0; b = 32'h1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (seen == 0 || o !== LT) begin
      errors++;
      $display("FAIL backpressure_result: seen=%0d o=%b, want 1 %b", seen, o, LT);
    end
    held = o;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = (c == 1);
      s = 1'b1; a = 32'hFFFF_FFFF; b = 32'h7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (o !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d unstable cycles, o=%b out_valid=%b in_ready=%b, want 0 %b 1 0",
               bad, o, out_valid, in_ready, held);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_ignored_pulse: busy=%b out_valid=%b in_ready=%b, want 0 0 1",
               busy, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_in_cmp();
    logic [5:0] obs;
    int lat;
    int leaked;
    @(negedge clk);
    s = 1'b0; a = 32'h1234_5678; b = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || o !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_cmp: out_valid=%b in_ready=%b busy=%b o=%b, want 0 1 0 000000",
               out_valid, in_ready, busy, o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    leaked = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) leaked++;
    end
    checks++;
    if (leaked != 0) begin
      errors++;
      $display("FAIL reset_abort_no_result: %0d cycles with out_valid/busy, want 0", leaked);
    end
    drive_txn(1'b0, 32'd5, 32'd3, obs, lat);
    checks++;
    if (obs !== GT || lat != 4) begin
      errors++;
      $display("FAIL after_reset_5_gt_3: o=%b lat=%0d, want %b lat=4", obs, lat, GT);
    end
  endtask

  task automatic test_k1();
    logic [7:0] av, bv;
    logic sv;
    logic [5:0] want;
    for (int t = 0; t < 10; t++) begin
      sv = 1'($urandom);
      av = 8'($urandom);
      bv = (t % 3 == 0) ? av : 8'($urandom);
      if (av == bv) want = EQ;
      else if (sv) want = ($signed(av) < $signed(bv)) ? LT : GT;
      else want = (av < bv) ? LT : GT;
      @(negedge clk);
      s1 = sv; a1 = av; b1 = bv; in_valid1 = 1'b1;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid1 !== 1'b1 || o1 !== want) begin
        errors++;
        $display("FAIL k1_latency_one s=%b a=%h b=%h: out_valid=%b o=%b, want 1 %b",
                 sv, av, bv, out_valid1, o1, want);
      end
      out_ready1 = 1'b1;
      @(posedge clk);
      #1;
      out_ready1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_order();
    test_signed_msb();
    test_all_ones();
    test_random();
    test_backpressure();
    test_reset_in_cmp();
    test_k1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
